// File: rtl/hdmi_out_fill_ctrl.sv
// Write-side fill scheduler for the HDMI output FIFO: splits each frame into DDR
// read bursts, issues them one at a time and forwards returned beats into the FIFO.
module hdmi_out_fill_ctrl #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int BURST_LEN = 16,
  parameter int BEATS_W   = 20
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  input  logic               frame_start,
  input  logic [ADDR_W-1:0]  frame_base_addr,
  input  logic [BEATS_W-1:0] frame_beats,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [4:0]         rd_len,
  input  logic               rd_ack,
  input  logic               rd_data_valid,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic               fifo_almost_full,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DATA_W-1:0]  fifo_wr_data,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow_err
);

  localparam int BYTES_PER_BEAT = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROOM,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  function automatic logic [4:0] burst_len_f(input logic [BEATS_W-1:0] rem);
    if (rem < BEATS_W'(BURST_LEN)) burst_len_f = rem[4:0];
    else                           burst_len_f = 5'(BURST_LEN);
  endfunction

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr, pend_addr, ld_addr;
  logic [BEATS_W-1:0]  remaining, pend_beats, ld_beats, rem_after;
  logic [4:0]          cmd_len, beat_cnt;
  logic                pend, zero_done, ovf;
  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;

  logic load_frame, set_pend, take_ack, advance, zero_pulse, clr_ovf;
  logic beat_in, last_beat, restart, write_beat, ld_zero;

  // A restart during a burst keeps the pending inputs unless a newer pulse arrives
  // on the very edge that finishes the drain.
  assign ld_addr    = frame_start ? frame_base_addr : pend_addr;
  assign ld_beats   = frame_start ? frame_beats : pend_beats;
  assign ld_zero    = (ld_beats == '0);
  assign rem_after  = remaining - BEATS_W'(cmd_len);
  assign beat_in    = (state == S_DATA) && rd_data_valid;
  assign last_beat  = beat_in && (beat_cnt == 5'd1);
  assign restart    = pend || frame_start;
  assign write_beat = beat_in && !restart;

  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    set_pend   = 1'b0;
    take_ack   = 1'b0;
    advance    = 1'b0;
    zero_pulse = 1'b0;
    clr_ovf    = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          load_frame = 1'b1;
          clr_ovf    = 1'b1;
          zero_pulse = ld_zero;
          state_nxt  = ld_zero ? S_IDLE : S_WAIT_ROOM;
        end
      end
      S_WAIT_ROOM: begin
        if (frame_start) begin
          load_frame = 1'b1;
          clr_ovf    = 1'b1;
          zero_pulse = ld_zero;
          state_nxt  = ld_zero ? S_IDLE : S_WAIT_ROOM;
        end else if (!fifo_almost_full) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        set_pend = frame_start;
        clr_ovf  = frame_start;
        if (rd_ack) begin
          take_ack  = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        set_pend = frame_start;
        clr_ovf  = frame_start;
        if (last_beat) begin
          if (restart) begin
            load_frame = 1'b1;
            zero_pulse = ld_zero;
            state_nxt  = ld_zero ? S_IDLE : S_WAIT_ROOM;
          end else begin
            advance   = 1'b1;
            state_nxt = (rem_after == '0) ? S_DONE : S_WAIT_ROOM;
          end
        end
      end
      S_DONE: begin
        if (frame_start) begin
          load_frame = 1'b1;
          clr_ovf    = 1'b1;
          zero_pulse = ld_zero;
          state_nxt  = ld_zero ? S_IDLE : S_WAIT_ROOM;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      pend       <= 1'b0;
      pend_addr  <= '0;
      pend_beats <= '0;
      cmd_len    <= '0;
      beat_cnt   <= '0;
      zero_done  <= 1'b0;
      ovf        <= 1'b0;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
    end else begin
      state     <= state_nxt;
      zero_done <= zero_pulse;

      if (load_frame) begin
        cur_addr  <= ld_addr;
        remaining <= ld_beats;
      end else if (advance) begin
        cur_addr  <= cur_addr + ADDR_W'(cmd_len) * ADDR_W'(BYTES_PER_BEAT);
        remaining <= rem_after;
      end

      if (load_frame)    pend <= 1'b0;
      else if (set_pend) pend <= 1'b1;
      if (set_pend) begin
        pend_addr  <= frame_base_addr;
        pend_beats <= frame_beats;
      end

      if (take_ack) begin
        cmd_len  <= rd_len;
        beat_cnt <= rd_len;
      end else if (beat_in) begin
        beat_cnt <= beat_cnt - 5'd1;
      end

      if (clr_ovf)                      ovf <= 1'b0;
      else if (write_beat && fifo_full) ovf <= 1'b1;

      // p1: registered FIFO write port, one cycle behind the returned beat
      vld_p1  <= write_beat && !fifo_full;
      data_p1 <= rd_data;
    end
  end

  assign rd_req       = (state == S_REQ);
  assign rd_addr      = cur_addr;
  assign rd_len       = burst_len_f(remaining);
  assign busy         = (state != S_IDLE);
  assign frame_done   = (state == S_DONE) || zero_done;
  assign overflow_err = ovf;
  assign fifo_wr_en   = vld_p1;
  assign fifo_wr_data = data_p1;

endmodule

// File: tb/tb_hdmi_out_fill_ctrl.sv
// Directed bench for hdmi_out_fill_ctrl: a simple DDR responder plus FIFO-side
// logging, with hand-computed command lists and beat sequences.
module tb_hdmi_out_fill_ctrl;

  localparam int ADDR_W    = 28;
  localparam int DATA_W    = 256;
  localparam int BURST_LEN = 16;
  localparam int BEATS_W   = 20;

  logic               clk;
  logic               wr_rst;
  logic               frame_start;
  logic [ADDR_W-1:0]  frame_base_addr;
  logic [BEATS_W-1:0] frame_beats;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic [4:0]         rd_len;
  logic               rd_ack;
  logic               rd_data_valid;
  logic [DATA_W-1:0]  rd_data;
  logic               fifo_almost_full;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DATA_W-1:0]  fifo_wr_data;
  logic               busy;
  logic               frame_done;
  logic               overflow_err;

  hdmi_out_fill_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .BEATS_W(BEATS_W)
  ) dut (
    .wr_clk(clk), .wr_rst(wr_rst), .frame_start(frame_start),
    .frame_base_addr(frame_base_addr), .frame_beats(frame_beats),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .frame_done(frame_done), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // DDR responder: ack one cycle after a request is seen, then beats back to back.
  // Beat payload is the beat's own byte address so order can be checked.
  int m_st = 0, m_addr = 0, m_len = 0, m_beat = 0, m_cur = -1;
  int cmd_addr[$];
  int cmd_len[$];

  initial begin
    rd_ack = 1'b0;
    rd_data_valid = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk); #1;
      rd_ack = 1'b0;
      rd_data_valid = 1'b0;
      case (m_st)
        0: if (rd_req) m_st = 1;
        1: begin
          rd_ack = 1'b1;
          m_addr = int'(rd_addr);
          m_len  = int'(rd_len);
          cmd_addr.push_back(m_addr);
          cmd_len.push_back(m_len);
          m_beat = 0;
          m_st   = 2;
        end
        default: begin
          rd_data_valid  = 1'b1;
          m_cur          = m_beat;
          rd_data        = '0;
          rd_data[31:0]  = m_addr + m_beat * 32;
          m_beat++;
          if (m_beat >= m_len) m_st = 0;
        end
      endcase
    end
  end

  // FIFO-side log sampled on the falling edge
  int wr_log[$];
  int n_done = 0, cyc = 0, done_cyc = 0, fall_cyc = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (fifo_wr_en) wr_log.push_back(int'(fifo_wr_data[31:0]));
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy_q && !busy) fall_cyc = cyc;
    busy_q = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic start_frame(input int base, input int beats);
    frame_base_addr = ADDR_W'(base);
    frame_beats     = BEATS_W'(beats);
    frame_start     = 1'b1;
    tick();
    frame_start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check_vec(tag, busy, 1'b0);
  endtask

  task automatic wait_beat(input string tag, input int idx, input int max);
    int n = 0;
    while (!(rd_data_valid && m_cur == idx) && n < max) begin
      tick();
      n++;
    end
    check_vec(tag, rd_data_valid && m_cur == idx, 1'b1);
  endtask

  int c0, w0, d0, w1, bad, reqs;

  initial begin
    wr_rst = 1'b1;
    frame_start = 1'b0;
    frame_base_addr = '0;
    frame_beats = '0;
    fifo_almost_full = 1'b0;
    fifo_full = 1'b0;
    #3;
    check_vec("rst_rd_req", rd_req, 0);
    check_vec("rst_rd_addr", rd_addr, 0);
    check_vec("rst_rd_len", rd_len, 0);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_frame_done", frame_done, 0);
    check_vec("rst_wr_en", fifo_wr_en, 0);
    check_vec("rst_wr_data", fifo_wr_data[63:0], 0);
    check_vec("rst_overflow", overflow_err, 0);
    tick(); tick();
    wr_rst = 1'b0;
    tick();

    // Basic frame split: 40 beats -> 16 + 16 + 8
    c0 = cmd_addr.size(); w0 = wr_log.size(); d0 = n_done;
    start_frame(32'h100000, 40);
    wait_idle("t1_timeout", 400);
    tick();
    check_vec("t1_ncmd", cmd_addr.size() - c0, 3);
    check_vec("t1_cmd0_addr", cmd_addr[c0], 32'h100000);
    check_vec("t1_cmd0_len", cmd_len[c0], 16);
    check_vec("t1_cmd1_addr", cmd_addr[c0+1], 32'h100200);
    check_vec("t1_cmd1_len", cmd_len[c0+1], 16);
    check_vec("t1_cmd2_addr", cmd_addr[c0+2], 32'h100400);
    check_vec("t1_cmd2_len", cmd_len[c0+2], 8);
    check_vec("t1_nwrites", wr_log.size() - w0, 40);
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (w0 + i >= wr_log.size() || wr_log[w0+i] != 32'h100000 + i * 32) bad++;
    check_vec("t1_order", bad, 0);
    check_vec("t1_ndone", n_done - d0, 1);
    check_vec("t1_busy_fall", fall_cyc - done_cyc, 1);
    check_vec("t1_overflow", overflow_err, 0);

    // Back-pressure after the first burst
    c0 = cmd_addr.size(); w0 = wr_log.size(); d0 = n_done;
    start_frame(0, 32);
    wait_beat("t2_first_last_beat", 15, 100);
    fifo_almost_full = 1'b1;
    reqs = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rd_req) reqs++;
    end
    check_vec("t2_req_during_hold", reqs, 0);
    fifo_almost_full = 1'b0;
    tick();
    check_vec("t2_req_after_drop", rd_req, 1);
    check_vec("t2_req_addr", rd_addr, 32'h200);
    check_vec("t2_req_len", rd_len, 16);
    wait_idle("t2_timeout", 200);
    tick();
    check_vec("t2_nwrites", wr_log.size() - w0, 32);
    check_vec("t2_ndone", n_done - d0, 1);

    // fifo_full on beats 3..4 of a single 16-beat burst
    w0 = wr_log.size(); d0 = n_done;
    start_frame(32'h300000, 16);
    begin
      int n = 0;
      do begin
        tick();
        fifo_full = rd_data_valid && (m_cur == 3 || m_cur == 4);
        n++;
      end while (busy && n < 200);
    end
    fifo_full = 1'b0;
    check_vec("t3_timeout", busy, 0);
    tick();
    check_vec("t3_nwrites", wr_log.size() - w0, 14);
    check_vec("t3_beat2", wr_log[w0+2], 32'h300000 + 2 * 32);
    check_vec("t3_skip_to_5", wr_log[w0+3], 32'h300000 + 5 * 32);
    check_vec("t3_overflow", overflow_err, 1);
    check_vec("t3_ndone", n_done - d0, 1);
    repeat (5) tick();
    check_vec("t3_overflow_sticky", overflow_err, 1);

    // Zero-length frame: also clears the sticky overflow
    c0 = cmd_addr.size(); d0 = n_done;
    start_frame(32'h123, 0);
    check_vec("t5_done_pulse", frame_done, 1);
    check_vec("t5_busy", busy, 0);
    check_vec("t5_overflow_cleared", overflow_err, 0);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_req) reqs++;
    end
    check_vec("t5_done_once", n_done - d0, 1);
    check_vec("t5_no_req", reqs, 0);

    // Restart at beat 5 of the first burst
    c0 = cmd_addr.size(); w0 = wr_log.size(); d0 = n_done;
    start_frame(32'h400000, 32);
    wait_beat("t4_reach_beat5", 5, 100);
    start_frame(32'h200000, 16);
    wait_idle("t4_timeout", 200);
    tick();
    check_vec("t4_nwrites", wr_log.size() - w0, 21);
    check_vec("t4_last_old", wr_log[w0+4], 32'h400000 + 4 * 32);
    check_vec("t4_first_new", wr_log[w0+5], 32'h200000);
    check_vec("t4_ncmd", cmd_addr.size() - c0, 2);
    check_vec("t4_cmd1_addr", cmd_addr[c0+1], 32'h200000);
    check_vec("t4_cmd1_len", cmd_len[c0+1], 16);
    check_vec("t4_ndone", n_done - d0, 1);

    // Async reset in the middle of a burst
    start_frame(32'h500000, 16);
    wait_beat("t6_reach_beat7", 7, 100);
    wr_rst = 1'b1;
    #1;
    check_vec("t6_rst_busy", busy, 0);
    check_vec("t6_rst_req", rd_req, 0);
    check_vec("t6_rst_wr_en", fifo_wr_en, 0);
    check_vec("t6_rst_done", frame_done, 0);
    tick();
    wr_rst = 1'b0;
    w1 = wr_log.size(); d0 = n_done;
    repeat (12) tick();
    check_vec("t6_ignored_beats", wr_log.size() - w1, 0);
    check_vec("t6_idle_after", busy, 0);
    c0 = cmd_addr.size(); w0 = wr_log.size();
    start_frame(32'h600000, 20);
    wait_idle("t6_timeout", 200);
    tick();
    check_vec("t6_ncmd", cmd_addr.size() - c0, 2);
    check_vec("t6_cmd1_addr", cmd_addr[c0+1], 32'h600200);
    check_vec("t6_cmd1_len", cmd_len[c0+1], 4);
    check_vec("t6_nwrites", wr_log.size() - w0, 20);
    check_vec("t6_last_beat", wr_log[w0+19], 32'h600000 + 19 * 32);
    check_vec("t6_ndone", n_done - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
